// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and data access,
// with data-side priority, a fetch starvation guard and flush-cancelled fetch responses.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state, state_nxt;
    logic [3:0] lat_cnt_p1;
    logic [3:0] starve_cnt;
    logic       own_if_p1, own_we_p1, kill_p1;
    logic       ret_p1, elig_p0, sel_if_p0, sel_dm_p0, kill_now;
    logic       unused_addr_bits;

    assign unused_addr_bits = ^{if_addr[1:0], dm_addr[1:0]};

    always_comb begin
        ret_p1    = (state == BUSY) && (lat_cnt_p1 == 4'd0);
        elig_p0   = !reset && ((state == IDLE) || ret_p1);
        sel_if_p0 = elig_p0 && if_req && (!dm_req || (starve_cnt == STARVE_LIM));
        sel_dm_p0 = elig_p0 && dm_req && !sel_if_p0;
        kill_now  = kill_p1 || (own_if_p1 && if_flush);
        if_gnt    = sel_if_p0;
        dm_gnt    = sel_dm_p0;
    end

    always_comb begin
        state_nxt = state;
        if (sel_if_p0 || sel_dm_p0) begin
            state_nxt = BUSY;
        end else if (ret_p1) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // grant -> memory request stage (p1)
    always_ff @(posedge clock) begin
        if (reset) begin
            lat_cnt_p1 <= '0;
            starve_cnt <= '0;
            own_if_p1  <= 1'b0;
            own_we_p1  <= 1'b0;
            kill_p1    <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            mem_en <= sel_if_p0 || sel_dm_p0;
            if (sel_if_p0 || sel_dm_p0) begin
                mem_we     <= sel_dm_p0 && dm_we;
                mem_addr   <= sel_dm_p0 ? dm_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];
                mem_wdata  <= sel_dm_p0 ? dm_wdata : '0;
                own_if_p1  <= sel_if_p0;
                own_we_p1  <= sel_dm_p0 && dm_we;
                kill_p1    <= 1'b0;
                lat_cnt_p1 <= LAT_INIT;
            end else begin
                if ((state == BUSY) && (lat_cnt_p1 != 4'd0)) begin
                    lat_cnt_p1 <= lat_cnt_p1 - 4'd1;
                end
                // a flush in the grant cycle targets the access being retired, not the new one
                if ((state == BUSY) && own_if_p1 && if_flush) begin
                    kill_p1 <= 1'b1;
                end
            end
            if (!if_req || sel_if_p0) begin
                starve_cnt <= '0;
            end else if (sel_dm_p0 && (starve_cnt != STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    // return data -> response stage (p2)
    always_ff @(posedge clock) begin
        if (reset) begin
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            dm_rvalid <= 1'b0;
            dm_rdata  <= '0;
        end else begin
            if_rvalid <= ret_p1 && own_if_p1 && !kill_now;
            dm_rvalid <= ret_p1 && !own_if_p1;
            if (ret_p1 && own_if_p1 && !kill_now) begin
                if_rdata <= mem_rdata;
            end
            if (ret_p1 && !own_if_p1) begin
                dm_rdata <= own_we_p1 ? '0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a memory stub answers the port and a
// transaction-level model predicts grants, memory requests and responses per cycle.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int SMAX = 4;
    localparam int NCYC = 3000;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0, if_flush = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [AW-1:0] if_addr = '0, dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0, mem_rdata = '0;
    logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
    logic [AW-3:0] mem_addr;

    always #5 clock = ~clock;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic [31:0] pipe_d  [0:15];
    bit          pipe_v  [0:15];

    // model state: one access outstanding, one response and one memory strobe in flight
    bit          out_v, out_if, out_kill;
    int          out_g;
    logic [31:0] out_d;
    bit          rsp_v, rsp_if;
    int          rsp_cyc;
    logic [31:0] rsp_d;
    bit          me_v, me_we;
    int          me_cyc;
    logic [29:0] me_addr;
    logic [31:0] me_wd;
    int          free_at, starve, rate;
    bit          rst_prev, if_done, dm_done, elig, g_if, g_dm, e_ifv, e_dmv, e_me;
    logic [31:0] exp_ifd, exp_dmd, a;

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < 16; i++) pipe_v[i] = 0;
        out_v = 0; rsp_v = 0; me_v = 0; free_at = 0; starve = 0;
        rst_prev = 0; if_done = 0; dm_done = 0; exp_ifd = '0; exp_dmd = '0;

        for (int c = 0; c < NCYC; c++) begin
            @(negedge clock);
            if (mem_en === 1'b1) begin
                if (mem_we) mem[mem_addr[5:0]] = mem_wdata;
                else begin
                    pipe_v[(c + LAT) % 16] = 1;
                    pipe_d[(c + LAT) % 16] = mem[mem_addr[5:0]];
                end
            end
            if (pipe_v[c % 16]) begin
                mem_rdata = pipe_d[c % 16];
                pipe_v[c % 16] = 0;
            end else begin
                mem_rdata = $urandom;
            end

            reset = (c < 3) || ($urandom_range(0, 199) == 0);
            rate  = (c >= 1000 && c < 1400) ? 100 : 60;
            if (if_done) begin if_req = 0; if_done = 0; end
            if (dm_done) begin dm_req = 0; dm_done = 0; end
            if (!if_req && $urandom_range(0, 99) < rate) begin
                if_req  = 1;
                if_addr = $urandom;
            end
            if (!dm_req && $urandom_range(0, 99) < rate) begin
                dm_req   = 1;
                dm_we    = 1'($urandom_range(0, 1));
                dm_addr  = $urandom;
                dm_wdata = $urandom;
            end
            if_flush = ($urandom_range(0, 9) == 0);
            #1;

            if (c >= 1) begin
                if (rst_prev) begin
                    exp_ifd = '0;
                    exp_dmd = '0;
                    check_val("reset_mem_addr", mem_addr, 0);
                    check_val("reset_mem_we", mem_we, 0);
                    check_val("reset_mem_wdata", mem_wdata, 0);
                end
                e_ifv = rsp_v && rsp_cyc == c && rsp_if;
                e_dmv = rsp_v && rsp_cyc == c && !rsp_if;
                if (e_ifv) exp_ifd = rsp_d;
                if (e_dmv) exp_dmd = rsp_d;
                if (rsp_v && rsp_cyc == c) rsp_v = 0;
                check_val("if_rvalid", if_rvalid, e_ifv);
                check_val("if_rdata", if_rdata, exp_ifd);
                check_val("dm_rvalid", dm_rvalid, e_dmv);
                check_val("dm_rdata", dm_rdata, exp_dmd);
                e_me = me_v && me_cyc == c;
                check_val("mem_en", mem_en, e_me);
                if (e_me) begin
                    me_v = 0;
                    check_val("mem_addr", mem_addr, me_addr);
                    check_val("mem_we", mem_we, me_we);
                    if (me_we) check_val("mem_wdata", mem_wdata, me_wd);
                end
            end

            elig = !reset && c >= free_at;
            g_if = elig && if_req && (!dm_req || starve == SMAX);
            g_dm = elig && dm_req && !g_if;
            check_val("if_gnt", if_gnt, g_if);
            check_val("dm_gnt", dm_gnt, g_dm);

            if (out_v && out_if && if_flush && c > out_g) out_kill = 1;
            if (out_v && c == out_g + 1 + LAT) begin
                out_v = 0;
                if (!(out_if && out_kill)) begin
                    rsp_v = 1; rsp_cyc = c + 1; rsp_if = out_if; rsp_d = out_d;
                end
            end
            if (g_if || g_dm) begin
                out_v = 1; out_if = g_if; out_kill = 0; out_g = c;
                free_at = c + 1 + LAT;
                a = g_if ? if_addr : dm_addr;
                me_v = 1; me_cyc = c + 1; me_addr = a[31:2];
                me_we = g_dm && dm_we; me_wd = dm_wdata;
                if (g_dm && dm_we) begin
                    ref_mem[a[7:2]] = dm_wdata;
                    out_d = '0;
                end else begin
                    out_d = ref_mem[a[7:2]];
                end
                if (g_if) if_done = 1;
                if (g_dm) dm_done = 1;
            end

            if (!if_req || g_if) starve = 0;
            else if (g_dm && starve < SMAX) starve++;

            if (reset) begin
                out_v = 0;
                if (rsp_v && rsp_cyc > c) rsp_v = 0;
                if (me_v && me_cyc > c) me_v = 0;
                starve  = 0;
                free_at = c + 1;
            end
            rst_prev = reset;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
